// File: rtl/dmac_mi_lock_ctrl_pkg.sv
// Shared definitions for the master-interface channel lock controller:
// lock level encodings, FSM state encoding and request-to-channel mapping.
package dmac_mi_lock_ctrl_pkg;

  localparam logic [1:0] LVL_TFR = 2'd0;
  localparam logic [1:0] LVL_BLK = 2'd1;
  localparam logic [1:0] LVL_TXN = 2'd2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } lock_state_e;

  // Requests come in source/destination pairs, so the channel is req/2.
  function automatic logic [7:0] req_to_ch(input logic [7:0] req);
    return req >> 1;
  endfunction

endpackage

// File: rtl/dmac_lock_tmo_cnt.sv
// Lock timeout counter: held clear while i_clr, counts while i_en, and flags
// the cycle whose increment brings the count to all ones.
module dmac_lock_tmo_cnt #(
  parameter int TMO_W = 16
) (
  input  logic hclk,
  input  logic hreset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_hit
);

  localparam logic [TMO_W-1:0] HIT_AT = {TMO_W{1'b1}} - TMO_W'(1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge hclk) begin
    if (hreset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

  assign o_hit = i_en && (r_cnt == HIT_AT);

endmodule

// File: rtl/dmac_mi_lock_ctrl.sv
// Per-master-interface channel lock controller: latches the granted channel,
// masks all other requests at the arbiter and holds bus lock until release.
// Optional lock timeout is built when DMAH_LOCK_TIMEOUT_EN is defined.
module dmac_mi_lock_ctrl
  import dmac_mi_lock_ctrl_pkg::*;
#(
  parameter int NUM_CH       = 8,
  parameter int NUM_PER      = 2 * NUM_CH,
  parameter int LOG2_NUM_PER = 4,
  parameter int LOG2_NUM_CH  = 3,
  parameter int TMO_W        = 16
) (
  input  logic                    hclk,
  input  logic                    hreset,
  input  logic                    granted_mi,
  input  logic [LOG2_NUM_PER-1:0] grant_index_mi,
  input  logic [NUM_CH-1:0]       lock_ch_en,
  input  logic [2*NUM_CH-1:0]     lock_ch_lvl,
  input  logic [NUM_CH-1:0]       tfr_done,
  input  logic [NUM_CH-1:0]       blk_done,
  input  logic [NUM_CH-1:0]       txn_done,
  input  logic [NUM_CH-1:0]       ch_dis,
  output logic [NUM_PER-1:0]      mask_lck_ch,
  output logic                    lock_active,
  output logic [LOG2_NUM_CH-1:0]  lock_owner,
  output logic                    lock_tmo,
  output lock_state_e             o_dbg_state
);

  localparam logic [NUM_PER-1:0] PAIR = NUM_PER'(3);

  lock_state_e           r_state;
  logic [NUM_PER-1:0]    r_mask;
  logic [LOG2_NUM_CH-1:0] r_owner;
  logic [1:0]            r_lvl;
  logic                  r_lock_tmo;

  lock_state_e           w_state_nxt;
  logic [NUM_PER-1:0]    w_mask_nxt;
  logic [LOG2_NUM_CH-1:0] w_owner_nxt;
  logic [1:0]            w_lvl_nxt;
  logic                  w_tmo_nxt;

  logic [LOG2_NUM_CH-1:0] w_ch;
  logic                  w_gidx_ok;
  logic                  w_grant_ok;
  logic [1:0]            w_req_lvl;
  logic [NUM_PER-1:0]    w_mask_lock;
  logic                  w_release;
  logic                  w_tmo_hit;

  assign w_ch       = LOG2_NUM_CH'(req_to_ch(8'(grant_index_mi)));
  assign w_gidx_ok  = 32'(grant_index_mi) < NUM_PER;
  assign w_grant_ok = granted_mi && w_gidx_ok && lock_ch_en[w_ch] && !ch_dis[w_ch];
  assign w_req_lvl  = lock_ch_lvl[{w_ch, 1'b0} +: 2];
  // A single-channel interface has nothing to exclude, so it never masks.
  assign w_mask_lock = (NUM_CH > 1) ? ~(PAIR << {w_ch, 1'b0}) : '0;

  always_comb begin
    w_release = ch_dis[r_owner] | tfr_done[r_owner];
    case (r_lvl)
      LVL_TFR: w_release = w_release;
      LVL_BLK: w_release = w_release | blk_done[r_owner];
      default: w_release = w_release | blk_done[r_owner] | txn_done[r_owner];
    endcase
  end

`ifdef DMAH_LOCK_TIMEOUT_EN
  dmac_lock_tmo_cnt #(
    .TMO_W (TMO_W)
  ) u_tmo_cnt (
    .hclk   (hclk),
    .hreset (hreset),
    .i_clr  (r_state == ST_IDLE),
    .i_en   (r_state == ST_LOCKED),
    .o_hit  (w_tmo_hit)
  );
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Grants seen while LOCKED (stale or owner re-grant) are deliberately ignored;
  // release always lands in IDLE so a new lock needs at least one idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_owner_nxt = r_owner;
    w_lvl_nxt   = r_lvl;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_ok) begin
          w_state_nxt = ST_LOCKED;
          w_mask_nxt  = w_mask_lock;
          w_owner_nxt = w_ch;
          w_lvl_nxt   = w_req_lvl;
        end
      end
      ST_LOCKED: begin
        if (w_release) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
        end else if (w_tmo_hit) begin
          w_state_nxt = ST_IDLE;
          w_mask_nxt  = '0;
          w_tmo_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_mask_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= ST_IDLE;
      r_mask     <= '0;
      r_owner    <= '0;
      r_lvl      <= LVL_TFR;
      r_lock_tmo <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mask     <= w_mask_nxt;
      r_owner    <= w_owner_nxt;
      r_lvl      <= w_lvl_nxt;
      r_lock_tmo <= w_tmo_nxt;
    end
  end

  assign mask_lck_ch = r_mask;
  assign lock_active = (r_state == ST_LOCKED);
  assign lock_owner  = r_owner;
  assign lock_tmo    = r_lock_tmo;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmac_mi_lock_ctrl.sv
// Directed bench for dmac_mi_lock_ctrl (NUM_CH = 4): the driver pushes the
// hand-computed output word for each cycle, a monitor pops and compares it.
module tb_dmac_mi_lock_ctrl;
  import dmac_mi_lock_ctrl_pkg::*;

  localparam int NUM_CH = 4;
  localparam int NUM_PER = 8;
  localparam int LOG2_NUM_PER = 4;
  localparam int LOG2_NUM_CH = 2;
  localparam int TMO_W = 4;
  localparam int EXP_W = NUM_PER + 1 + LOG2_NUM_CH + 1 + 1;

  logic                    hclk = 1'b0;
  logic                    hreset;
  logic                    granted_mi;
  logic [LOG2_NUM_PER-1:0] grant_index_mi;
  logic [NUM_CH-1:0]       lock_ch_en;
  logic [2*NUM_CH-1:0]     lock_ch_lvl;
  logic [NUM_CH-1:0]       tfr_done;
  logic [NUM_CH-1:0]       blk_done;
  logic [NUM_CH-1:0]       txn_done;
  logic [NUM_CH-1:0]       ch_dis;
  logic [NUM_PER-1:0]      mask_lck_ch;
  logic                    lock_active;
  logic [LOG2_NUM_CH-1:0]  lock_owner;
  logic                    lock_tmo;
  lock_state_e             o_dbg_state;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  int               checks = 0;
  int               failures = 0;

  dmac_mi_lock_ctrl #(
    .NUM_CH       (NUM_CH),
    .NUM_PER      (NUM_PER),
    .LOG2_NUM_PER (LOG2_NUM_PER),
    .LOG2_NUM_CH  (LOG2_NUM_CH),
    .TMO_W        (TMO_W)
  ) dut (
    .hclk           (hclk),
    .hreset         (hreset),
    .granted_mi     (granted_mi),
    .grant_index_mi (grant_index_mi),
    .lock_ch_en     (lock_ch_en),
    .lock_ch_lvl    (lock_ch_lvl),
    .tfr_done       (tfr_done),
    .blk_done       (blk_done),
    .txn_done       (txn_done),
    .ch_dis         (ch_dis),
    .mask_lck_ch    (mask_lck_ch),
    .lock_active    (lock_active),
    .lock_owner     (lock_owner),
    .lock_tmo       (lock_tmo),
    .o_dbg_state    (o_dbg_state)
  );

  // Clock and reset
  always #5 hclk = ~hclk;

  // Monitor: sample 1 time unit after each rising edge.
  always @(posedge hclk) begin
    logic [EXP_W-1:0] exp_v;
    logic [EXP_W-1:0] got_v;
    string            nm;
    #1;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {mask_lck_ch, lock_active, lock_owner, lock_tmo, logic'(o_dbg_state)};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s: got mask=%b act=%b own=%0d tmo=%b st=%b, expected mask=%b act=%b own=%0d tmo=%b st=%b",
                 nm, got_v[EXP_W-1 -: NUM_PER], got_v[4+LOG2_NUM_CH-1], got_v[2 +: LOG2_NUM_CH],
                 got_v[1], got_v[0], exp_v[EXP_W-1 -: NUM_PER], exp_v[4+LOG2_NUM_CH-1],
                 exp_v[2 +: LOG2_NUM_CH], exp_v[1], exp_v[0]);
      end
    end
  end

  // Driver: inputs already set; queue the outputs expected after the next edge.
  task automatic cyc(input string nm, input logic [NUM_PER-1:0] m, input logic a,
                     input logic [LOG2_NUM_CH-1:0] o, input logic t);
    exp_q.push_back({m, a, o, t, a});
    name_q.push_back(nm);
    @(negedge hclk);
  endtask

  initial begin
    hreset = 1'b1; granted_mi = 1'b0; grant_index_mi = '0; lock_ch_en = '0;
    lock_ch_lvl = '0; tfr_done = '0; blk_done = '0; txn_done = '0; ch_dis = '0;
    @(negedge hclk);
    cyc("reset", 8'h00, 1'b0, 2'd0, 1'b0);
    hreset = 1'b0;

    // Transfer-level lock on channel 2 via its destination request.
    lock_ch_en = 4'b0100; granted_mi = 1'b1; grant_index_mi = 4'd5;
    cyc("entry", 8'hCF, 1'b1, 2'd2, 1'b0);
    granted_mi = 1'b0;
    lock_ch_lvl[5:4] = 2'd2;
    cyc("hold_lvl_change", 8'hCF, 1'b1, 2'd2, 1'b0);
    txn_done = 4'b0100;
    cyc("txn_no_rel", 8'hCF, 1'b1, 2'd2, 1'b0);
    txn_done = '0; blk_done = 4'b0100;
    cyc("blk_no_rel", 8'hCF, 1'b1, 2'd2, 1'b0);
    blk_done = '0; tfr_done = 4'b0100;
    cyc("tfr_rel", 8'h00, 1'b0, 2'd2, 1'b0);
    tfr_done = '0;
    cyc("idle_after_rel", 8'h00, 1'b0, 2'd2, 1'b0);

    // Transaction-level lock on channel 1.
    lock_ch_lvl = 8'b0000_1000; lock_ch_en = 4'b0010; granted_mi = 1'b1; grant_index_mi = 4'd2;
    cyc("lvl2_entry", 8'hF3, 1'b1, 2'd1, 1'b0);
    granted_mi = 1'b0; txn_done = 4'b1000; tfr_done = 4'b0001;
    cyc("other_done_ign", 8'hF3, 1'b1, 2'd1, 1'b0);
    txn_done = '0; tfr_done = '0;
    lock_ch_en = 4'b1010; granted_mi = 1'b1; grant_index_mi = 4'd6;
    cyc("nonowner_grant", 8'hF3, 1'b1, 2'd1, 1'b0);
    grant_index_mi = 4'd3;
    cyc("owner_regrant", 8'hF3, 1'b1, 2'd1, 1'b0);
    granted_mi = 1'b0; lock_ch_en = 4'b0010; txn_done = 4'b0010;
    cyc("txn1_rel", 8'h00, 1'b0, 2'd1, 1'b0);
    txn_done = '0;

    // No lock enabled; then out-of-range indices with all enables set.
    lock_ch_en = '0; granted_mi = 1'b1;
    for (int i = 0; i < 10; i++) begin
      grant_index_mi = LOG2_NUM_PER'(i);
      cyc("no_lock", 8'h00, 1'b0, 2'd1, 1'b0);
    end
    lock_ch_en = 4'b1111;
    for (int i = 8; i < 16; i++) begin
      grant_index_mi = LOG2_NUM_PER'(i);
      cyc("oob_index", 8'h00, 1'b0, 2'd1, 1'b0);
    end
    granted_mi = 1'b0;

    // Release and new grant in the same cycle.
    lock_ch_en = 4'b1001; lock_ch_lvl = '0; granted_mi = 1'b1; grant_index_mi = 4'd0;
    cyc("own0_entry", 8'hFC, 1'b1, 2'd0, 1'b0);
    tfr_done = 4'b0001; grant_index_mi = 4'd6;
    cyc("sim_release", 8'h00, 1'b0, 2'd0, 1'b0);
    tfr_done = '0;
    cyc("sim_new_lock", 8'h3F, 1'b1, 2'd3, 1'b0);
    granted_mi = 1'b0;

    // Abort of the owner, then no lock while still disabled.
    ch_dis = 4'b1000;
    cyc("abort_rel", 8'h00, 1'b0, 2'd3, 1'b0);
    granted_mi = 1'b1; grant_index_mi = 4'd7;
    cyc("dis_no_lock", 8'h00, 1'b0, 2'd3, 1'b0);
    ch_dis = '0;
    cyc("relock", 8'h3F, 1'b1, 2'd3, 1'b0);
    granted_mi = 1'b0;

    // Reset mid-lock.
    hreset = 1'b1;
    cyc("reset_mid", 8'h00, 1'b0, 2'd0, 1'b0);
    hreset = 1'b0;
    cyc("post_reset", 8'h00, 1'b0, 2'd0, 1'b0);

    // Long hold without done pulses on channel 1.
    lock_ch_en = 4'b0010; granted_mi = 1'b1; grant_index_mi = 4'd3;
    cyc("long_entry", 8'hF3, 1'b1, 2'd1, 1'b0);
    granted_mi = 1'b0;
`ifdef DMAH_LOCK_TIMEOUT_EN
    for (int i = 0; i < 14; i++) cyc("tmo_hold", 8'hF3, 1'b1, 2'd1, 1'b0);
    cyc("tmo_pulse", 8'h00, 1'b0, 2'd1, 1'b1);
    cyc("tmo_after", 8'h00, 1'b0, 2'd1, 1'b0);
`else
    for (int i = 0; i < 100; i++) cyc("persist", 8'hF3, 1'b1, 2'd1, 1'b0);
    tfr_done = 4'b0010;
    cyc("persist_rel", 8'h00, 1'b0, 2'd1, 1'b0);
    tfr_done = '0;
`endif
    cyc("final_idle", 8'h00, 1'b0, 2'd1, 1'b0);

    @(negedge hclk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
